// File: rtl/rtc_bus_sequencer_if.sv
// Pad-side signals of the multiplexed address/data RTC bus.
// The sequencer is the master; the pad ring or device model is the slave.
interface rtc_bus_sequencer_if;
   logic [7:0] bus_in;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic       ad_n;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;

   modport master (
      input  bus_in,
      output bus_out, bus_oe, ad_n, cs_n, rd_n, wr_n
   );

   modport slave (
      output bus_in,
      input  bus_out, bus_oe, ad_n, cs_n, rd_n, wr_n
   );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Sweep engine for the multiplexed RTC bus: one start runs up to NREG
// masked register accesses (all reads or all writes) and buffers read-back bytes.
module rtc_bus_sequencer #(
   parameter int NREG = 9,
   parameter int T_PH = 2,
   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 wr_mode,
   input  logic [NREG-1:0]      en_mask,
   input  logic [8*NREG-1:0]    addr_list,
   input  logic [8*NREG-1:0]    wdata_list,
   rtc_bus_sequencer_if.master  bus,
   output logic [8*NREG-1:0]    rdata_list,
   output logic                 rd_valid,
   output logic [IW-1:0]        rd_idx,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = IW + 1;
   localparam int TW = (T_PH > 1) ? $clog2(T_PH) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(T_PH - 1);
   localparam logic [2:0]    PH_DS = 3'd4;
   localparam logic [2:0]    PH_DH = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic       ad_n;
      logic       cs_n;
      logic       rd_n;
      logic       wr_n;
      logic       oe;
      logic [7:0] dout;
   } drive_t;

   localparam drive_t DRIVE_IDLE = '{ad_n: 1'b1, cs_n: 1'b1, rd_n: 1'b1,
                                     wr_n: 1'b1, oe: 1'b0, dout: 8'h00};

   // Pad drive for phase ph (AS, AW, AH, GP, DS, DH) of one access.
   function automatic drive_t phase_drive(input logic [2:0] ph, input logic wr,
                                          input logic [7:0] addr, input logic [7:0] wdat);
      drive_t d;
      d = DRIVE_IDLE;
      case (ph)
         3'd0: begin
            d.ad_n = 1'b0; d.oe = 1'b1; d.dout = addr;
         end
         3'd1: begin
            d.ad_n = 1'b0; d.cs_n = 1'b0; d.wr_n = 1'b0; d.oe = 1'b1; d.dout = addr;
         end
         3'd2: begin
            d.ad_n = 1'b0; d.oe = 1'b1; d.dout = addr;
         end
         3'd3, 3'd5: begin
            d.oe = wr; d.dout = wr ? wdat : 8'h00;
         end
         3'd4: begin
            d.cs_n = 1'b0; d.rd_n = wr; d.wr_n = ~wr;
            d.oe = wr; d.dout = wr ? wdat : 8'h00;
         end
         default: d = DRIVE_IDLE;
      endcase
      return d;
   endfunction

   state_t              state_r;
   logic                mode_r;
   logic [NREG-1:0]     mask_r;
   logic [8*NREG-1:0]   addr_r;
   logic [8*NREG-1:0]   wdata_r;
   logic [CW-1:0]       cand_r;
   logic [IW-1:0]       slot_r;
   logic [2:0]          phase_r;
   logic [TW-1:0]       tick_r;
   drive_t              drive_r;
   logic [8*NREG-1:0]   rdata_r;
   logic                rd_valid_r;
   logic [IW-1:0]       rd_idx_r;
   logic                busy_r;
   logic                done_r;

   logic [CW-1:0]       cand_s;
   logic [NREG-1:0]     remaining_s;
   logic                tick_last_s;
   logic                advance_s;
   logic [7:0]          cand_addr_s;
   logic [7:0]          slot_addr_s;
   logic [7:0]          slot_wdata_s;

   // Next-slot candidate and look-ahead over the slots still to be scanned.
   always_comb begin
      cand_s = {CW{1'b0}};
      if (state_r == ST_SCAN) begin
         cand_s = cand_r;
      end else begin
         cand_s = {1'b0, slot_r} + CW'(1);
      end
      // Nothing enabled at or above the candidate means the sweep is over.
      remaining_s = mask_r >> cand_s;
      tick_last_s = (tick_r == TICK_LAST);
      if (state_r == ST_SCAN) begin
         advance_s = 1'b1;
      end else if ((state_r == ST_ACCESS) && tick_last_s && (phase_r == PH_DH)) begin
         advance_s = 1'b1;
      end else begin
         advance_s = 1'b0;
      end
      cand_addr_s  = addr_r[{cand_s[IW-1:0], 3'b000} +: 8];
      slot_addr_s  = addr_r[{slot_r, 3'b000} +: 8];
      slot_wdata_s = wdata_r[{slot_r, 3'b000} +: 8];
   end

   // Sweep FSM with registered bus drive, read-back buffer and status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         mode_r     <= 1'b0;
         mask_r     <= {NREG{1'b0}};
         addr_r     <= {(8*NREG){1'b0}};
         wdata_r    <= {(8*NREG){1'b0}};
         cand_r     <= {CW{1'b0}};
         slot_r     <= {IW{1'b0}};
         phase_r    <= 3'd0;
         tick_r     <= {TW{1'b0}};
         drive_r    <= DRIVE_IDLE;
         rdata_r    <= {(8*NREG){1'b0}};
         rd_valid_r <= 1'b0;
         rd_idx_r   <= {IW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         rd_valid_r <= 1'b0;
         done_r     <= 1'b0;
         if (advance_s) begin
            if (remaining_s == {NREG{1'b0}}) begin
               state_r <= ST_DONE;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               drive_r <= DRIVE_IDLE;
            end else if (remaining_s[0]) begin
               state_r <= ST_ACCESS;
               slot_r  <= cand_s[IW-1:0];
               phase_r <= 3'd0;
               tick_r  <= {TW{1'b0}};
               drive_r <= phase_drive(3'd0, mode_r, cand_addr_s, 8'h00);
            end else begin
               // Disabled slot: one idle cycle, bus released.
               state_r <= ST_SCAN;
               cand_r  <= cand_s + CW'(1);
               drive_r <= DRIVE_IDLE;
            end
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start) begin
                     mode_r  <= wr_mode;
                     mask_r  <= en_mask;
                     addr_r  <= addr_list;
                     wdata_r <= wdata_list;
                     cand_r  <= {CW{1'b0}};
                     busy_r  <= 1'b1;
                     state_r <= ST_SCAN;
                  end
               end
               ST_ACCESS: begin
                  if (tick_last_s) begin
                     tick_r  <= {TW{1'b0}};
                     phase_r <= phase_r + 3'd1;
                     drive_r <= phase_drive(phase_r + 3'd1, mode_r, slot_addr_s, slot_wdata_s);
                     if ((phase_r == PH_DS) && !mode_r) begin
                        rdata_r[{slot_r, 3'b000} +: 8] <= bus.bus_in;
                        rd_valid_r <= 1'b1;
                        rd_idx_r   <= slot_r;
                     end
                  end else begin
                     tick_r <= tick_r + TW'(1);
                  end
               end
               ST_DONE: begin
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  drive_r <= DRIVE_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ad_n    = drive_r.ad_n;
   assign bus.cs_n    = drive_r.cs_n;
   assign bus.rd_n    = drive_r.rd_n;
   assign bus.wr_n    = drive_r.wr_n;
   assign bus.bus_oe  = drive_r.oe;
   assign bus.bus_out = drive_r.dout;
   assign rdata_list  = rdata_r;
   assign rd_valid    = rd_valid_r;
   assign rd_idx      = rd_idx_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised bus master for the multiplexed address/data RTC interface: performs a sweep of up to NREG register accesses (all reads or all writes) per start request, with programmable phase length and a per-slot enable mask. It replaces the fixed single-access read/write cycle engines under the controller FSM. It also buffers the read-back bytes for the display path. The controller issues one start per sweep instead of sequencing individual accesses.

## Interface
Parameters:
- NREG, 9: register slots per sweep (1..16); IW = max(1, $clog2(NREG))
- T_PH, 2: clock cycles per bus phase (>=1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  sweep request, sampled only when busy=0
- wr_mode  in  1  1 = write sweep, 0 = read sweep (sampled with start)
- en_mask  in  NREG  slot i accessed when bit i = 1 (sampled with start)
- addr_list  in  8*NREG  slot i address at [8i+7:8i]
- wdata_list  in  8*NREG  slot i write data, same packing
- bus_in  in  8  pad input from bidirectional AD bus
- bus_out  out  8  pad drive value
- bus_oe  out  1  1 = drive bus_out onto pads, 0 = high-Z
- ad_n, cs_n, rd_n, wr_n  out  1 each  active-low bus strobes
- rdata_list  out  8*NREG  read-back buffer, same packing
- rd_valid  out  1  one-cycle pulse when a read byte is stored
- rd_idx  out  IW  slot index of the byte stored with rd_valid
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

## Operation
- Reset values: ad_n=cs_n=rd_n=wr_n=1, bus_oe=0, bus_out=0, rdata_list=0, rd_valid=0, rd_idx=0, busy=0, done=0. All outputs are registered.
- IDLE: on start=1, latch wr_mode, en_mask, addr_list, wdata_list into shadow registers; set busy. Later input changes have no effect on the sweep.
- Slot scan: ascending from slot 0. Slots with mask bit 0 are skipped with zero bus cycles; the pointer advances by one slot per clock while skipping.
- Each access is six phases of T_PH cycles each:
  - AS (addr setup): ad_n=0, bus_oe=1, bus_out=addr.
  - AW (addr strobe): ad_n=0, cs_n=0, wr_n=0, addr driven.
  - AH (addr hold): ad_n=0, strobes high, addr driven.
  - GP (gap): ad_n=1, all strobes high. Read: bus_oe=0. Write: bus_oe=1, bus_out=wdata.
  - DS (data strobe): cs_n=0. Read: rd_n=0, bus_oe=0. Write: wr_n=0, wdata driven.
  - DH (data hold): strobes high. Write keeps driving wdata; read keeps bus_oe=0.
- Read capture: bus_in is sampled on the last cycle of DS into rdata_list slot i. rd_valid=1 and rd_idx=i are asserted the following cycle. Write sweeps never modify rdata_list.
- End: after DH of the last enabled slot (or after scanning with none left), go to DONE for one cycle: done=1, busy=0, bus_oe=0. Then return to IDLE.
- start while busy=1 is ignored; it is not queued.
- en_mask all zero: no bus activity; done still pulses.
- Reset mid-sweep: immediate return to reset values (strobes high, bus released). rdata_list is cleared and the partial sweep is lost.
- Strobes are never asserted with cs_n=0 while bus_oe toggles within the same phase. bus_oe changes only at phase boundaries.

## Timing
- start sampled at edge 0 → AS begins at edge 1 (if slot 0 is enabled). Each skipped slot ahead of the first enabled slot adds one cycle.
- Per access: 6*T_PH cycles. Consecutive enabled slots run back to back: DH of slot i is followed directly by AS of slot i+1.
- done pulses on the cycle after the final DH cycle. busy is high from edge 1 through the final DH cycle.
- Full sweep, all enabled: done at cycle 1 + 6*T_PH*NREG after start.
- rd_valid lags the DS sample edge by one cycle and precedes the DH phase end.

## Test plan
- Read sweep, NREG=9, T_PH=2, mask=9'h1FF, addr 0x21..0x29, bus model returns addr^0xFF → nine rd_valid pulses with rd_idx 0..8, rdata slot i = ~addr, done at cycle 109, each cs_n low window exactly 2 cycles.
- Write sweep, mask=9'h001, addr 0x41, wdata 0x5A → single access, bus model logs addr 0x41 / data 0x5A; rdata_list unchanged; done at cycle 13; no rd_valid.
- Mask skip: mask=9'b100000100, read → accesses only slots 2 and 8, two rd_valid pulses (idx 2, 8); other slots keep their prior values.
- Mask zero → done pulse within 10 cycles, cs_n stays 1, bus_oe stays 0 throughout.
- Reset asserted during DS of slot 3 → same cycle: all strobes 1, bus_oe=0, busy=0, rdata_list=0; next start runs a full sweep correctly.
- start re-pulsed mid-sweep and addr_list changed mid-sweep → ignored; the sweep uses the originally latched addresses; exactly one done pulse.
